// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin two-master req/ack sequencer (m0_*/m1_* in, registered sys_* MMIO bus out, busy)
module sys_bus_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ack,
  output logic              sys_rd,
  output logic              sys_wr,
  output logic              sys_mmio_cs,
  output logic [ADDR_W-1:0] sys_addr,
  output logic [DATA_W-1:0] sys_wr_data,
  input  logic [DATA_W-1:0] sys_rd_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT == 0 ? 0 : RD_WAIT - 1);
  state_t     state;
  state_t     state_n;
  logic       prio;
  logic       gnt;
  logic       wr_q;
  logic       gnt_n;
  logic       wr_sel;
  logic       grant;
  logic       ack_n;
  logic [3:0] cnt;
  always_comb begin
    gnt_n   = m0_req & m1_req ? prio : m1_req;
    wr_sel  = gnt_n ? m1_wr : m0_wr;
    grant   = state == IDLE & (m0_req | m1_req);
    state_n = state;
    case (state)
      IDLE:    state_n = grant ? ISSUE : IDLE;
      ISSUE:   state_n = RD_WAIT == 0 ? ACK : WAIT;
      WAIT:    state_n = cnt == 4'd0 ? ACK : WAIT;
      default: state_n = IDLE;
    endcase
    ack_n = state_n == ACK & state != ACK;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prio        <= 1'b0;
      gnt         <= 1'b0;
      wr_q        <= 1'b0;
      cnt         <= 4'd0;
      sys_rd      <= 1'b0;
      sys_wr      <= 1'b0;
      sys_mmio_cs <= 1'b0;
      sys_addr    <= '0;
      sys_wr_data <= '0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sys_mmio_cs <= grant;
      sys_rd      <= grant & ~wr_sel;
      sys_wr      <= grant & wr_sel;
      busy        <= state_n != IDLE;
      m0_ack      <= ack_n & ~gnt;
      m1_ack      <= ack_n & gnt;
      cnt         <= state == ISSUE ? WAIT_INIT : state == WAIT ? cnt - 4'd1 : cnt;
      if (grant) begin
        gnt         <= gnt_n;
        prio        <= ~gnt_n;
        wr_q        <= wr_sel;
        sys_addr    <= gnt_n ? m1_addr : m0_addr;
        sys_wr_data <= gnt_n ? m1_wr_data : m0_wr_data;
      end
      if (ack_n & ~wr_q & ~gnt) m0_rd_data <= sys_rd_data;
      if (ack_n & ~wr_q & gnt)  m1_rd_data <= sys_rd_data;
    end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed vector table plus corner sequences on RD_WAIT=0/2/3 instances
module tb_sys_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [20:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data, rd_data;
  logic        sys_rd [3];
  logic        sys_wr [3];
  logic        sys_cs [3];
  logic        m0_ack [3];
  logic        m1_ack [3];
  logic        busy [3];
  logic [20:0] sys_addr [3];
  logic [31:0] sys_wd [3];
  logic [31:0] m0_rd [3];
  logic [31:0] m1_rd [3];
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sys_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .RD_WAIT(g == 0 ? 0 : g + 1)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_rd_data(m0_rd[g]), .m0_ack(m0_ack[g]),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_rd_data(m1_rd[g]), .m1_ack(m1_ack[g]),
      .sys_rd(sys_rd[g]), .sys_wr(sys_wr[g]), .sys_mmio_cs(sys_cs[g]),
      .sys_addr(sys_addr[g]), .sys_wr_data(sys_wd[g]), .sys_rd_data(rd_data),
      .busy(busy[g])
    );
  end
  typedef struct {
    logic [4:0]  in_f;
    logic [20:0] a0;
    logic [31:0] d0;
    logic [20:0] a1;
    logic [31:0] d1;
    logic [31:0] rdat;
    logic [5:0]  ex_f;
    logic [20:0] ex_a;
    logic [31:0] ex_d;
    logic [31:0] ex_r0;
    logic [31:0] ex_r1;
  } vec_t;
  vec_t tbl [20];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [122:0] got, input logic [122:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [122:0] obs(input int g);
    return {sys_cs[g], sys_rd[g], sys_wr[g], m0_ack[g], m1_ack[g], busy[g],
            sys_addr[g], sys_wd[g], m0_rd[g], m1_rd[g]};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    m0_wr = 1'b0;
    m1_wr = 1'b0;
    step();
    reset = 1'b0;
  endtask
  initial begin
    // in_f = {rst, m0_req, m0_wr, m1_req, m1_wr}; ex_f = {cs, rd, wr, m0_ack, m1_ack, busy}
    tbl[0]  = '{5'b01100, 21'h41,  32'hDEADBEEF, 21'h0,   32'h0,        32'h0,        6'b101001, 21'h41,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[1]  = '{5'b01100, 21'h41,  32'hDEADBEEF, 21'h0,   32'h0,        32'h0,        6'b000101, 21'h41,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[2]  = '{5'b00000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h41,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[3]  = '{5'b00000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h41,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[4]  = '{5'b10000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h0,   32'h0,        32'h0,        32'h0};
    tbl[5]  = '{5'b01011, 21'h100, 32'h0,        21'h200, 32'hA5A5A5A5, 32'h0,        6'b110001, 21'h100, 32'h0,        32'h0,        32'h0};
    tbl[6]  = '{5'b01011, 21'h100, 32'h0,        21'h200, 32'hA5A5A5A5, 32'h11112222, 6'b000101, 21'h100, 32'h0,        32'h11112222, 32'h0};
    tbl[7]  = '{5'b00011, 21'h100, 32'h0,        21'h200, 32'hA5A5A5A5, 32'h0,        6'b000000, 21'h100, 32'h0,        32'h11112222, 32'h0};
    tbl[8]  = '{5'b00011, 21'h100, 32'h0,        21'h200, 32'hA5A5A5A5, 32'h0,        6'b101001, 21'h200, 32'hA5A5A5A5, 32'h11112222, 32'h0};
    tbl[9]  = '{5'b00011, 21'h100, 32'h0,        21'h200, 32'hA5A5A5A5, 32'h77777777, 6'b000011, 21'h200, 32'hA5A5A5A5, 32'h11112222, 32'h0};
    tbl[10] = '{5'b00000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h200, 32'hA5A5A5A5, 32'h11112222, 32'h0};
    tbl[11] = '{5'b01010, 21'h300, 32'h0,        21'h400, 32'h0,        32'h0,        6'b110001, 21'h300, 32'h0,        32'h11112222, 32'h0};
    tbl[12] = '{5'b01010, 21'h300, 32'h0,        21'h400, 32'h0,        32'hCAFEF00D, 6'b000101, 21'h300, 32'h0,        32'hCAFEF00D, 32'h0};
    tbl[13] = '{5'b00010, 21'h300, 32'h0,        21'h400, 32'h0,        32'h0,        6'b000000, 21'h300, 32'h0,        32'hCAFEF00D, 32'h0};
    tbl[14] = '{5'b00010, 21'h300, 32'h0,        21'h400, 32'h0,        32'h0,        6'b110001, 21'h400, 32'h0,        32'hCAFEF00D, 32'h0};
    tbl[15] = '{5'b00010, 21'h300, 32'h0,        21'h400, 32'h0,        32'h0BADF00D, 6'b000011, 21'h400, 32'h0,        32'hCAFEF00D, 32'h0BADF00D};
    tbl[16] = '{5'b00000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h400, 32'h0,        32'hCAFEF00D, 32'h0BADF00D};
    tbl[17] = '{5'b01100, 21'h55,  32'h01020304, 21'h0,   32'h0,        32'hFFFFFFFF, 6'b101001, 21'h55,  32'h01020304, 32'hCAFEF00D, 32'h0BADF00D};
    tbl[18] = '{5'b01100, 21'h55,  32'h01020304, 21'h0,   32'h0,        32'hFFFFFFFF, 6'b000101, 21'h55,  32'h01020304, 32'hCAFEF00D, 32'h0BADF00D};
    tbl[19] = '{5'b00000, 21'h0,   32'h0,        21'h0,   32'h0,        32'h0,        6'b000000, 21'h55,  32'h01020304, 32'hCAFEF00D, 32'h0BADF00D};
    reset = 1'b1;
    {m0_req, m0_wr, m1_req, m1_wr} = 4'b0;
    m0_addr = '0;
    m1_addr = '0;
    m0_wr_data = '0;
    m1_wr_data = '0;
    rd_data = '0;
    step();
    step();
    chk("reset_state", obs(0), '0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      {reset, m0_req, m0_wr, m1_req, m1_wr} = tbl[i].in_f;
      m0_addr = tbl[i].a0;
      m0_wr_data = tbl[i].d0;
      m1_addr = tbl[i].a1;
      m1_wr_data = tbl[i].d1;
      rd_data = tbl[i].rdat;
      step();
      chk($sformatf("vec%0d", i), obs(0),
          {tbl[i].ex_f, tbl[i].ex_a, tbl[i].ex_d, tbl[i].ex_r0, tbl[i].ex_r1});
    end
    // m1 read through two wait cycles
    do_reset();
    m1_req = 1'b1;
    m1_wr = 1'b0;
    m1_addr = 21'h1F000;
    rd_data = 32'h12345678;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("rw2_c%0d", k),
          {sys_cs[1], sys_rd[1], sys_wr[1], m1_ack[1], m0_ack[1], busy[1], sys_addr[1]},
          {k == 1, k == 1, 1'b0, k == 4, 1'b0, k != 5, 21'h1F000});
      if (k == 4) m1_req = 1'b0;
    end
    chk("rw2_rdata", m1_rd[1], 32'h12345678);
    // continuous contention: strict alternation with one idle cycle between transactions
    do_reset();
    m0_req = 1'b1;
    m0_wr = 1'b0;
    m0_addr = 21'h10;
    m1_req = 1'b1;
    m1_wr = 1'b0;
    m1_addr = 21'h20;
    for (int k = 1; k <= 18; k++) begin
      int  ph;
      logic who;
      ph = k % 3;
      who = 1'(((k - 1) / 3) % 2);
      step();
      chk($sformatf("alt_c%0d", k),
          {sys_cs[0], m0_ack[0], m1_ack[0], busy[0], sys_addr[0]},
          {ph == 1, ph == 2 && !who, ph == 2 && who, ph != 0, who ? 21'h20 : 21'h10});
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    // reset during the wait phase abandons the transaction
    do_reset();
    m0_req = 1'b1;
    m0_wr = 1'b0;
    m0_addr = 21'h33;
    step();
    step();
    chk("rst_in_wait", {sys_cs[2], busy[2]}, 2'b01);
    reset = 1'b1;
    m0_req = 1'b0;
    #1;
    chk("rst_async_drop", {sys_cs[2], sys_rd[2], sys_wr[2], m0_ack[2], m1_ack[2], busy[2]}, 6'b0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rst_no_ack_c%0d", k), {m0_ack[2], m1_ack[2], busy[2], sys_cs[2]}, 4'b0);
    end
    m0_req = 1'b1;
    m0_addr = 21'h44;
    m1_req = 1'b1;
    m1_wr = 1'b0;
    m1_addr = 21'h66;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("rst_resume_c%0d", k), {sys_cs[2], m0_ack[2], m1_ack[2], sys_addr[2]},
          {k == 1, k == 5, 1'b0, 21'h44});
      if (k == 5) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    // req dropped and fields changed after grant
    do_reset();
    m0_req = 1'b1;
    m0_wr = 1'b1;
    m0_addr = 21'h77;
    m0_wr_data = 32'h1234;
    step();
    chk("drop_issue", {sys_cs[0], sys_wr[0], sys_addr[0], sys_wd[0]}, {2'b11, 21'h77, 32'h1234});
    m0_req = 1'b0;
    m0_addr = 21'h99;
    m0_wr_data = 32'h9999;
    for (int k = 2; k <= 6; k++) begin
      step();
      chk($sformatf("drop_c%0d", k), {sys_cs[0], m0_ack[0], sys_addr[0], sys_wd[0]},
          {1'b0, k == 2, 21'h77, 32'h1234});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
